// File: rtl/seven_seg_capture_if.sv
// Pin-level bundle between a multiplexed 3-digit seven-segment display and its capture block.
// The master drives segments and digit selects; the slave returns the reassembled frame.
interface seven_seg_capture_if;
    logic [6:0] seg;    // {g,f,e,d,c,b,a}
    logic [2:0] ca;     // active-low digit select
    logic [9:0] value;
    logic       valid;
    logic       err;
    logic       ovf;

    modport master (
        output seg, ca,
        input  value, valid, err, ovf
    );

    modport slave (
        input  seg, ca,
        output value, valid, err, ovf
    );
endinterface

// File: rtl/seven_seg_capture.sv
// Captures a multiplexed 3-digit seven-segment scan: debounces each digit dwell,
// decodes segments back to BCD and emits the reassembled binary value once per frame.
module seven_seg_capture #(
    parameter int STABLE_CYCLES  = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    seven_seg_capture_if.slave bus
);

    localparam int                CNT_W   = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES);

    // {ca, active-high seg}
    logic [9:0]       smp;
    logic [9:0]       smp_next;
    logic [CNT_W-1:0] cnt;

    logic [3:0] ones, tens, hund;
    logic [2:0] mask;           // {hund, tens, ones} captured in this frame
    logic [2:0] bad;

    logic [9:0] value_q;
    logic       valid_q, err_q, ovf_q;

    logic       accept;
    logic [2:0] pos_sel;
    logic [2:0] acc;
    logic [3:0] dec_digit;
    logic       dec_bad;
    logic       complete;
    logic [2:0] mask_base, bad_base;
    logic [9:0] frame_sum;
    logic [9:0] h10, t10, o10;

    assign smp_next = {bus.ca, (SEG_ACTIVE_LOW ? ~bus.seg : bus.seg)};

    // The sample being loaded equals the held one and the count is one short of
    // saturation: this is the single edge on which cnt reaches STABLE_CYCLES.
    assign accept   = (smp_next == smp) && (cnt == CNT_MAX - 1'b1);
    assign complete = (mask == 3'b111);

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        pos_sel = 3'b000;
        unique case (smp[9:7])
            3'b110:  pos_sel = 3'b001;
            3'b101:  pos_sel = 3'b010;
            3'b011:  pos_sel = 3'b100;
            default: pos_sel = 3'b000;
        endcase
    end

    always_comb begin
        dec_digit = 4'd0;
        dec_bad   = 1'b0;
        case (smp[6:0])
            7'h3F:   dec_digit = 4'd0;
            7'h06:   dec_digit = 4'd1;
            7'h5B:   dec_digit = 4'd2;
            7'h4F:   dec_digit = 4'd3;
            7'h66:   dec_digit = 4'd4;
            7'h6D:   dec_digit = 4'd5;
            7'h7D:   dec_digit = 4'd6;
            7'h07:   dec_digit = 4'd7;
            7'h7F:   dec_digit = 4'd8;
            7'h6F:   dec_digit = 4'd9;
            default: dec_bad   = 1'b1;
        endcase
    end

    assign acc = accept ? pos_sel : 3'b000;

    // A completing frame hands its mask/bad state over to the next frame on the same
    // edge, so an acceptance coinciding with completion seeds the new frame.
    assign mask_base = complete ? 3'b000 : mask;
    assign bad_base  = complete ? 3'b000 : bad;

    assign h10 = {6'd0, hund};
    assign t10 = {6'd0, tens};
    assign o10 = {6'd0, ones};
    assign frame_sum = (h10 << 6) + (h10 << 5) + (h10 << 2)
                     + (t10 << 3) + (t10 << 1) + o10;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            smp     <= '0;
            cnt     <= '0;
            ones    <= '0;
            tens    <= '0;
            hund    <= '0;
            mask    <= '0;
            bad     <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            smp <= smp_next;
            if (smp_next != smp)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;

            if (acc[0]) ones <= dec_digit;
            if (acc[1]) tens <= dec_digit;
            if (acc[2]) hund <= dec_digit;

            mask    <= mask_base | acc;
            bad     <= (bad_base & ~acc) | (acc & {3{dec_bad}});
            valid_q <= complete;

            if (complete) begin
                value_q <= frame_sum;
                err_q   <= |bad;
                ovf_q   <= (frame_sum > 10'd255);
            end
        end
    end

    assign bus.value = value_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture: stimulus pushes hand-computed frames,
// a negedge monitor pops and compares on every valid pulse.
module tb_seven_seg_capture;

    localparam logic [2:0] ONES  = 3'b110;
    localparam logic [2:0] TENS  = 3'b101;
    localparam logic [2:0] HUND  = 3'b011;
    localparam logic [2:0] BLANK = 3'b111;

    typedef struct {
        int value;
        int err;
        int ovf;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    seven_seg_capture_if bus ();

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    seven_seg_capture #(
        .STABLE_CYCLES  (16),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [6:0] pat(input int d);
        logic [6:0] p;
        case (d)
            0: p = 7'h3F;  1: p = 7'h06;  2: p = 7'h5B;  3: p = 7'h4F;
            4: p = 7'h66;  5: p = 7'h6D;  6: p = 7'h7D;  7: p = 7'h07;
            8: p = 7'h7F;  9: p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    // Called at posedge+1; pins hold for exactly n active edges, returns at posedge+1.
    task automatic dwell(input logic [2:0] ca_v, input logic [6:0] lit, input int n);
        bus.ca  = ca_v;
        bus.seg = ~lit;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input int v, input int e, input int o, input string tag);
        exp_t x;
        x.value = v; x.err = e; x.ovf = o; x.tag = tag;
        exp_q.push_back(x);
    endtask

    task automatic scan(input int h, input int t, input int o, input int v, input int ovf_e,
                        input string tag);
        expect_frame(v, 0, ovf_e, tag);
        dwell(ONES, pat(o), 40);
        dwell(TENS, pat(t), 40);
        dwell(HUND, pat(h), 40);
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check({x.tag, "_value"}, int'(bus.value), x.value);
                check({x.tag, "_err"},   int'(bus.err),   x.err);
                check({x.tag, "_ovf"},   int'(bus.ovf),   x.ovf);
            end
        end
    end

    initial begin
        int lat;
        bus.ca  = BLANK;
        bus.seg = 7'h7F;
        rst     = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_value", int'(bus.value), 0);
        check("reset_valid", int'(bus.valid), 0);
        check("reset_err",   int'(bus.err),   0);
        check("reset_ovf",   int'(bus.ovf),   0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 42 with latency measured from the first edge carrying the hundreds dwell
        expect_frame(42, 0, 0, "f042");
        dwell(ONES, pat(2), 40);
        dwell(TENS, pat(4), 40);
        bus.ca  = HUND;
        bus.seg = ~pat(0);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid && lat == 0) lat = i;
        end
        check("latency_f042", lat, 18);

        scan(9, 9, 9, 999, 1, "f999");
        scan(2, 5, 5, 255, 0, "f255");

        // glitch inside the ones dwell, short wrong-digit dwell before tens
        expect_frame(731, 0, 1, "f731");
        dwell(ONES, pat(1), 5);
        dwell(ONES, 7'h7F, 1);
        dwell(ONES, pat(1), 40);
        dwell(TENS, pat(8), 10);
        dwell(TENS, pat(3), 40);
        dwell(HUND, pat(7), 40);

        // undecodable tens pattern
        expect_frame(103, 1, 0, "f123bad");
        dwell(ONES, pat(3), 40);
        dwell(TENS, 7'h49, 40);
        dwell(HUND, pat(1), 40);

        // blanking gaps and an all-low select held long
        expect_frame(86, 0, 0, "f086");
        dwell(BLANK, 7'h00, 20);
        dwell(ONES, pat(6), 40);
        dwell(BLANK, 7'h00, 20);
        dwell(3'b000, pat(8), 100);
        dwell(TENS, pat(8), 40);
        dwell(BLANK, 7'h00, 20);
        dwell(HUND, pat(0), 40);
        dwell(BLANK, 7'h00, 20);

        // reset after two accepted digits discards the partial frame
        dwell(ONES, pat(5), 40);
        dwell(TENS, pat(5), 40);
        bus.ca  = BLANK;
        bus.seg = 7'h7F;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midreset_value", int'(bus.value), 0);
        check("midreset_valid", int'(bus.valid), 0);
        check("midreset_err",   int'(bus.err),   0);
        check("midreset_ovf",   int'(bus.ovf),   0);
        rst = 1'b0;

        expect_frame(7, 0, 0, "f007");
        dwell(ONES, pat(7), 60);
        dwell(TENS, pat(0), 40);
        dwell(HUND, pat(0), 40);
        dwell(BLANK, 7'h00, 40);

        check("pending_frames", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
